// File: rtl/sync_ram_dp.sv
`default_nettype none
// ============================================================================
//  Module   : sync_ram_dp
//  Brief    : Simple dual-port synchronous RAM with byte strobes, a self-clear
//             sequence after reset, selectable read-during-write behaviour and
//             optional output register.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_ram_dp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [ADDR_WIDTH-1:0]     wr_adr,
    input  logic [DATA_WIDTH-1:0]     wr_dat,
    input  logic [DATA_WIDTH/8-1:0]   wr_sel,
    input  logic                      re,
    input  logic [ADDR_WIDTH-1:0]     rd_adr,
    output logic [DATA_WIDTH-1:0]     rd_dat,
    output logic                      rd_vld,
    output logic                      busy
);

    localparam int NSEL  = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word_d;
    logic [DATA_WIDTH-1:0]   rd1_dat_q;
    logic                    rd1_vld_q;
    logic                    rd_en;

    assign busy  = (state_q == CLEAR);
    assign rd_en = re && (state_q == READY);

    // The counter wraps back to zero on the same edge that leaves CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else if (state_q == CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
                state_q <= READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem[clr_cnt_q] <= '0;
            end else if (we) begin
                for (int i = 0; i < NSEL; i++) begin
                    if (wr_sel[i]) begin
                        mem[wr_adr][8*i +: 8] <= wr_dat[8*i +: 8];
                    end
                end
            end
        end
    end

    // New-data mode forwards the strobed bytes of a colliding write.
    always_comb begin
        rd_word_d = mem[rd_adr];
        if ((RDW_MODE != 0) && we && (wr_adr == rd_adr)) begin
            for (int i = 0; i < NSEL; i++) begin
                if (wr_sel[i]) begin
                    rd_word_d[8*i +: 8] = wr_dat[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_dat_q <= '0;
            rd1_vld_q <= 1'b0;
        end else begin
            rd1_vld_q <= rd_en;
            if (rd_en) begin
                rd1_dat_q <= rd_word_d;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] rd2_dat_q;
        logic                  rd2_vld_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd2_dat_q <= '0;
                rd2_vld_q <= 1'b0;
            end else begin
                rd2_vld_q <= rd1_vld_q;
                if (rd1_vld_q) begin
                    rd2_dat_q <= rd1_dat_q;
                end
            end
        end

        assign rd_dat = rd2_dat_q;
        assign rd_vld = rd2_vld_q;
    end else begin : g_no_out_reg
        assign rd_dat = rd1_dat_q;
        assign rd_vld = rd1_vld_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_ram_dp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_ram_dp
//  Brief    : Directed bench driving two sync_ram_dp instances (old-data /
//             latency 1 and new-data / latency 2) from shared stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_ram_dp;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] wr_adr;
    logic [DW-1:0] wr_dat;
    logic [3:0]    wr_sel;
    logic          re;
    logic [AW-1:0] rd_adr;
    logic [DW-1:0] rd_dat0, rd_dat1;
    logic          rd_vld0, rd_vld1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .we(we), .wr_adr(wr_adr), .wr_dat(wr_dat),
        .wr_sel(wr_sel), .re(re), .rd_adr(rd_adr),
        .rd_dat(rd_dat0), .rd_vld(rd_vld0), .busy(busy0)
    );

    sync_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .we(we), .wr_adr(wr_adr), .wr_dat(wr_dat),
        .wr_sel(wr_sel), .re(re), .rd_adr(rd_adr),
        .rd_dat(rd_dat1), .rd_vld(rd_vld1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        we = 1'b1; wr_adr = a; wr_dat = d; wr_sel = s;
        tick();
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wr_adr = '0; wr_dat = '0; wr_sel = '0;
        re = 1'b0; rd_adr = '0;
        tick(); tick();
        check("reset_busy0", 32'(busy0), 32'd1);
        check("reset_busy1", 32'(busy1), 32'd1);
        check("reset_vld0", 32'(rd_vld0), 32'd0);
        check("reset_vld1", 32'(rd_vld1), 32'd0);
        check("reset_dat0", rd_dat0, 32'h0);
        check("reset_dat1", rd_dat1, 32'h0);

        // Clear sequence with write and read requests that must be ignored
        rst = 1'b0;
        we = 1'b1; wr_adr = 4'd3; wr_dat = 32'hFFFF_FFFF; wr_sel = 4'hF;
        re = 1'b1; rd_adr = 4'd3;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("clr_busy0_%0d", i), 32'(busy0), 32'd1);
            check($sformatf("clr_busy1_%0d", i), 32'(busy1), 32'd1);
            check($sformatf("clr_vld0_%0d", i), 32'(rd_vld0), 32'd0);
            check($sformatf("clr_vld1_%0d", i), 32'(rd_vld1), 32'd0);
            check($sformatf("clr_dat0_%0d", i), rd_dat0, 32'h0);
            tick();
        end
        we = 1'b0; re = 1'b0;
        check("clr_done_busy0", 32'(busy0), 32'd0);
        check("clr_done_busy1", 32'(busy1), 32'd0);
        check("clr_done_vld0", 32'(rd_vld0), 32'd0);
        tick();
        check("clr_done_vld1", 32'(rd_vld1), 32'd0);

        re = 1'b1; rd_adr = 4'd3;
        tick();
        re = 1'b0;
        check("rd3_vld0", 32'(rd_vld0), 32'd1);
        check("rd3_dat0", rd_dat0, 32'h0);
        check("rd3_vld1_early", 32'(rd_vld1), 32'd0);
        tick();
        check("rd3_vld1", 32'(rd_vld1), 32'd1);
        check("rd3_dat1", rd_dat1, 32'h0);

        // Byte-strobed writes
        write(4'd5, 32'h1122_3344, 4'b1111);
        write(4'd5, 32'hAABB_CCDD, 4'b0101);
        re = 1'b1; rd_adr = 4'd5;
        tick();
        re = 1'b0;
        check("bytes_vld0", 32'(rd_vld0), 32'd1);
        check("bytes_dat0", rd_dat0, 32'h11BB_33DD);
        check("bytes_vld1_early", 32'(rd_vld1), 32'd0);
        tick();
        check("bytes_vld0_pulse", 32'(rd_vld0), 32'd0);
        check("bytes_hold0", rd_dat0, 32'h11BB_33DD);
        check("bytes_vld1", 32'(rd_vld1), 32'd1);
        check("bytes_dat1", rd_dat1, 32'h11BB_33DD);
        tick();
        check("bytes_vld1_pulse", 32'(rd_vld1), 32'd0);
        check("bytes_hold1", rd_dat1, 32'h11BB_33DD);

        write(4'd5, 32'h0000_0000, 4'b0000);
        re = 1'b1; rd_adr = 4'd5;
        tick();
        re = 1'b0;
        check("nosel_dat0", rd_dat0, 32'h11BB_33DD);

        // Full-throughput readback
        for (int a = 0; a < 16; a++) write(4'(a), 32'(a) * 32'h0101_0101, 4'hF);
        tick();
        for (int a = 0; a < 16; a++) begin
            re = 1'b1; rd_adr = 4'(a);
            tick();
            check($sformatf("b2b_vld0_%0d", a), 32'(rd_vld0), 32'd1);
            check($sformatf("b2b_dat0_%0d", a), rd_dat0, 32'(a) * 32'h0101_0101);
            if (a == 0) begin
                check("b2b_vld1_first", 32'(rd_vld1), 32'd0);
            end else begin
                check($sformatf("b2b_vld1_%0d", a), 32'(rd_vld1), 32'd1);
                check($sformatf("b2b_dat1_%0d", a), rd_dat1, 32'(a - 1) * 32'h0101_0101);
            end
        end
        re = 1'b0;
        tick();
        check("b2b_tail_vld0", 32'(rd_vld0), 32'd0);
        check("b2b_tail_vld1", 32'(rd_vld1), 32'd1);
        check("b2b_tail_dat1", rd_dat1, 32'h0F0F_0F0F);

        // Read-during-write, same address
        write(4'd7, 32'h0, 4'hF);
        we = 1'b1; wr_adr = 4'd7; wr_dat = 32'hDEAD_BEEF; wr_sel = 4'b0011;
        re = 1'b1; rd_adr = 4'd7;
        tick();
        we = 1'b0; re = 1'b0;
        check("rdw_old_dat0", rd_dat0, 32'h0000_0000);
        tick();
        check("rdw_new_dat1", rd_dat1, 32'h0000_BEEF);

        // Read-during-write, different addresses
        we = 1'b1; wr_adr = 4'd8; wr_dat = 32'h5555_5555; wr_sel = 4'hF;
        re = 1'b1; rd_adr = 4'd9;
        tick();
        we = 1'b0; re = 1'b0;
        check("rdw_diff_dat0", rd_dat0, 32'h0909_0909);
        tick();
        check("rdw_diff_dat1", rd_dat1, 32'h0909_0909);
        re = 1'b1; rd_adr = 4'd8;
        tick();
        re = 1'b0;
        check("rdw_diff_wr8", rd_dat0, 32'h5555_5555);
        tick();

        // Reset with a read in flight, then reset again mid-clear
        re = 1'b1; rd_adr = 4'd9;
        tick();
        check("flight_vld0", 32'(rd_vld0), 32'd1);
        rst = 1'b1; re = 1'b0;
        tick();
        rst = 1'b0; re = 1'b1;
        check("flight_vld1", 32'(rd_vld1), 32'd0);
        check("flight_dat0", rd_dat0, 32'h0);
        check("flight_busy", 32'(busy0), 32'd1);
        for (int i = 0; i < 9; i++) tick();
        check("midclr_busy", 32'(busy0), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("reclr_busy0_%0d", i), 32'(busy0), 32'd1);
            check($sformatf("reclr_vld0_%0d", i), 32'(rd_vld0), 32'd0);
            check($sformatf("reclr_vld1_%0d", i), 32'(rd_vld1), 32'd0);
            tick();
        end
        re = 1'b0;
        check("reclr_done_busy0", 32'(busy0), 32'd0);
        check("reclr_done_busy1", 32'(busy1), 32'd0);
        check("reclr_done_vld0", 32'(rd_vld0), 32'd0);
        tick();
        check("reclr_done_vld1", 32'(rd_vld1), 32'd0);

        // Memory must be zero again after the restarted clear
        for (int a = 7; a < 10; a++) begin
            re = 1'b1; rd_adr = 4'(a);
            tick();
            check($sformatf("zero_vld0_%0d", a), 32'(rd_vld0), 32'd1);
            check($sformatf("zero_dat0_%0d", a), rd_dat0, 32'h0);
        end
        re = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
